// File: rtl/conv_layer_sched.sv
// Layer scheduler: walks a descriptor table, configures and launches the conv
// engine per layer, flips the ping-pong buffer select and watches for engine hangs.
module conv_layer_sched #(
  parameter int MAX_LAYERS = 8,
  parameter int CH_W       = 6,
  parameter int DIM_W      = 8,
  parameter int TO_CYCLES  = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [CH_W-1:0]               cfg_in_ch,
  input  logic [CH_W-1:0]               cfg_out_ch,
  input  logic [DIM_W-1:0]              cfg_dim,
  input  logic                          cfg_relu,
  input  logic [$clog2(MAX_LAYERS):0]   num_layers,
  input  logic                          start,
  input  logic                          eng_done,
  output logic                          eng_start,
  output logic [CH_W-1:0]               eng_in_ch,
  output logic [CH_W-1:0]               eng_out_ch,
  output logic [DIM_W-1:0]              eng_dim,
  output logic                          eng_relu,
  output logic                          buf_sel,
  output logic [$clog2(MAX_LAYERS)-1:0] layer_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int AW     = $clog2(MAX_LAYERS);
  localparam int NW     = AW + 1;
  localparam int WD_W   = $clog2(TO_CYCLES);
  localparam int DESC_W = 2 * CH_W + DIM_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CONFIG, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  state_t            state_q;
  logic [NW-1:0]     num_q;
  logic [WD_W-1:0]   wd_q;
  logic [AW-1:0]     layer_idx_q;
  logic              buf_sel_q, eng_start_q, busy_q, done_q, err_q, eng_relu_q;
  logic [CH_W-1:0]   eng_in_ch_q, eng_out_ch_q;
  logic [DIM_W-1:0]  eng_dim_q;

  // Descriptor storage survives rst so a run can be repeated without reloading.
  logic [DESC_W-1:0] table_q [MAX_LAYERS];
  logic [DESC_W-1:0] desc;
  logic              last_layer;

  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE)
      table_q[cfg_addr] <= {cfg_in_ch, cfg_out_ch, cfg_dim, cfg_relu};
  end

  assign desc       = table_q[layer_idx_q];
  assign last_layer = ({1'b0, layer_idx_q} == num_q - NW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      wd_q         <= '0;
      layer_idx_q  <= '0;
      buf_sel_q    <= 1'b0;
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      eng_in_ch_q  <= '0;
      eng_out_ch_q <= '0;
      eng_dim_q    <= '0;
      eng_relu_q   <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q       <= num_layers;
            err_q       <= 1'b0;
            layer_idx_q <= '0;
            buf_sel_q   <= 1'b0;
            busy_q      <= 1'b1;
            if (num_layers == '0)                    state_q <= S_FINISH;
            else if (num_layers > NW'(MAX_LAYERS))   state_q <= S_ERROR;
            else                                     state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          eng_in_ch_q  <= desc[DESC_W-1 -: CH_W];
          eng_out_ch_q <= desc[DIM_W+CH_W : DIM_W+1];
          eng_dim_q    <= desc[DIM_W:1];
          eng_relu_q   <= desc[0];
          state_q      <= S_CONFIG;
        end
        S_CONFIG: state_q <= S_LAUNCH;
        S_LAUNCH: begin
          eng_start_q <= 1'b1;
          wd_q        <= '0;
          state_q     <= S_WAIT;
        end
        // Completion takes priority over a watchdog expiring in the same cycle.
        S_WAIT: begin
          if (eng_done)                             state_q <= S_NEXT;
          else if (wd_q == WD_W'(TO_CYCLES - 1))    state_q <= S_ERROR;
          else                                      wd_q    <= wd_q + WD_W'(1);
        end
        S_NEXT: begin
          buf_sel_q <= ~buf_sel_q;
          if (last_layer) begin
            state_q <= S_FINISH;
          end else begin
            layer_idx_q <= layer_idx_q + AW'(1);
            state_q     <= S_FETCH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_in_ch  = eng_in_ch_q;
  assign eng_out_ch = eng_out_ch_q;
  assign eng_dim    = eng_dim_q;
  assign eng_relu   = eng_relu_q;
  assign buf_sel    = buf_sel_q;
  assign layer_idx  = layer_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: an engine responder plus a table/latency model
// predicting each launch, the buffer select sequence and done/err outcomes.
module tb_conv_layer_sched;

  logic       clk, rst, cfg_we, cfg_relu, start, eng_done;
  logic [2:0] cfg_addr;
  logic [5:0] cfg_in_ch, cfg_out_ch;
  logic [7:0] cfg_dim;
  logic [3:0] num_layers;
  logic       eng_start, eng_relu, buf_sel, busy, done, err;
  logic [5:0] eng_in_ch, eng_out_ch;
  logic [7:0] eng_dim;
  logic [2:0] layer_idx;

  conv_layer_sched #(.MAX_LAYERS(8), .CH_W(6), .DIM_W(8), .TO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_dim(cfg_dim),
    .cfg_relu(cfg_relu), .num_layers(num_layers), .start(start),
    .eng_done(eng_done), .eng_start(eng_start), .eng_in_ch(eng_in_ch),
    .eng_out_ch(eng_out_ch), .eng_dim(eng_dim), .eng_relu(eng_relu),
    .buf_sel(buf_sel), .layer_idx(layer_idx), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_starts = 0;
  int n_dones = 0;
  int n_chk = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (eng_start) n_starts <= n_starts + 1;
    if (done)      n_dones  <= n_dones + 1;
  end

  // Reference descriptor table: mirrors only writes made while the scheduler is idle.
  logic [5:0] m_in [8];
  logic [5:0] m_out[8];
  logic [7:0] m_dim[8];
  logic       m_relu[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({eng_start, eng_in_ch, eng_out_ch, eng_dim, eng_relu, buf_sel,
                layer_idx, busy, done, err});
  endfunction

  task automatic cfg_write(input int a, input int ic, input int oc, input int dm, input int rl);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_in_ch = 6'(ic); cfg_out_ch = 6'(oc);
    cfg_dim = 8'(dm); cfg_relu = 1'(rl);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_in[a] = 6'(ic); m_out[a] = 6'(oc); m_dim[a] = 8'(dm); m_relu[a] = 1'(rl);
  endtask

  task automatic pulse_start(input int num, output int n0);
    @(posedge clk); #1;
    start = 1'b1; num_layers = 4'(num);
    @(posedge clk); #1;
    n0 = cyc; start = 1'b0;
  endtask

  task automatic wait_eng(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic run(input int num, input int fixed_d, input bit spur,
                     input bit wr_wait, input bit wr_start, input string tag);
    int n0, t, m, exp_t, d, s0, d0;
    bit ok;
    s0 = n_starts; d0 = n_dones;
    @(posedge clk); #1;
    start = 1'b1; num_layers = 4'(num);
    if (spur) eng_done = 1'b1;
    if (wr_start) begin
      cfg_we = 1'b1; cfg_addr = 3'd0;
      cfg_in_ch = 6'($urandom); cfg_out_ch = 6'($urandom);
      cfg_dim = 8'($urandom); cfg_relu = 1'($urandom);
      m_in[0] = cfg_in_ch; m_out[0] = cfg_out_ch; m_dim[0] = cfg_dim; m_relu[0] = cfg_relu;
    end
    @(posedge clk); #1;
    n0 = cyc; start = 1'b0; cfg_we = 1'b0;
    if (spur) begin @(posedge clk); #1; eng_done = 1'b0; end
    exp_t = n0 + 3; m = 0;
    for (int i = 0; i < num; i++) begin
      wait_eng(t, ok);
      check($sformatf("%s_seen%0d", tag, i), 32'(ok), 32'd1);
      if (!ok) return;
      check($sformatf("%s_lat%0d", tag, i), 32'(t), 32'(exp_t));
      check($sformatf("%s_desc%0d", tag, i),
            32'({eng_in_ch, eng_out_ch, eng_dim, eng_relu}),
            32'({m_in[i], m_out[i], m_dim[i], m_relu[i]}));
      check($sformatf("%s_buf%0d", tag, i), 32'(buf_sel), 32'(i % 2));
      check($sformatf("%s_idx%0d", tag, i), 32'(layer_idx), 32'(i));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      d = (fixed_d > 0) ? fixed_d : $urandom_range(2, 12);
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        start  = spur && k == 0 && i == 0;
        cfg_we = wr_wait && k == 0 && i == 0;
        if (cfg_we) begin
          cfg_addr = 3'd0; cfg_in_ch = ~m_in[0]; cfg_out_ch = ~m_out[0];
          cfg_dim = ~m_dim[0]; cfg_relu = ~m_relu[0];
        end
      end
      eng_done = 1'b1; start = 1'b0; cfg_we = 1'b0;
      @(posedge clk); #1;
      m = cyc; eng_done = 1'b0;
      exp_t = m + 4;
    end
    ok = 1'b0; t = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; t = cyc; break; end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_done_lat"}, 32'(t), 32'(m + 2));
    check({tag, "_buf_end"}, 32'(buf_sel), 32'(num % 2));
    check({tag, "_idx_end"}, 32'(layer_idx), 32'(num - 1));
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_nstarts"}, 32'(n_starts - s0), 32'(num));
    check({tag, "_ndones"}, 32'(n_dones - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n0, t, s0, d0;
    bit ok;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_in_ch = '0; cfg_out_ch = '0;
    cfg_dim = '0; cfg_relu = 1'b0; num_layers = '0; start = 1'b0; eng_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;

    cfg_write(0, 15, 31, 32, 1);
    cfg_write(1, 31, 63, 16, 0);
    cfg_write(2, 63, 63, 8, 1);
    run(3, 4, 1'b0, 1'b0, 1'b0, "plan");

    // zero layers: straight to a done pulse with a single busy cycle
    s0 = n_starts; d0 = n_dones;
    pulse_start(0, n0);
    @(negedge clk);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_nodone_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy_off", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_nstarts", 32'(n_starts - s0), 32'd0);
    check("zero_ndones", 32'(n_dones - d0), 32'd1);

    // too many layers
    s0 = n_starts; d0 = n_dones;
    pulse_start(9, n0);
    @(negedge clk); @(negedge clk);
    check("over_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("over_nstarts", 32'(n_starts - s0), 32'd0);
    check("over_ndones", 32'(n_dones - d0), 32'd0);

    // engine never answers: watchdog fires
    s0 = n_starts; d0 = n_dones;
    pulse_start(2, n0);
    check("to_err_cleared", 32'(err), 32'd0);
    wait_eng(t, ok);
    check("to_seen", 32'(ok), 32'd1);
    begin
      int te; bit eok;
      eok = 1'b0; te = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (err) begin eok = 1'b1; te = cyc; break; end
      end
      check("to_err_seen", 32'(eok), 32'd1);
      check("to_err_lat", 32'(te), 32'(t + 17));
    end
    check("to_busy", 32'(busy), 32'd0);
    check("to_idx", 32'(layer_idx), 32'd0);
    repeat (3) @(negedge clk);
    check("to_nstarts", 32'(n_starts - s0), 32'd1);
    check("to_ndones", 32'(n_dones - d0), 32'd0);
    run(1, 0, 1'b0, 1'b0, 1'b0, "after_to");

    run(2, 0, 1'b0, 1'b1, 1'b0, "wrwait");
    run(2, 0, 1'b0, 1'b0, 1'b0, "after_wrwait");
    run(2, 0, 1'b0, 1'b0, 1'b1, "wrstart");
    run(3, 0, 1'b1, 1'b0, 1'b0, "spur");

    // asynchronous reset during layer 1
    pulse_start(3, n0);
    wait_eng(t, ok);
    check("rst_l0_seen", 32'(ok), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    wait_eng(t, ok);
    check("rst_l1_seen", 32'(ok), 32'd1);
    check("rst_l1_idx", 32'(layer_idx), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(3, 0, 1'b0, 1'b0, 1'b0, "post_rst");

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 8; a++)
        cfg_write(a, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      run(int'($urandom_range(1, 8)), 0, 1'($urandom), 1'b0, 1'b0,
          $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
